// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: a direct-mapped table of 2-bit saturating
// direction counters plus a branch target buffer, both held in flops.
// IF gets a combinational prediction for its PC. EX returns resolved
// branches, which train the table and raise a registered flush/redirect on
// a misprediction.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   if_pc              fetch PC to predict
//   pred_taken         predicted direction for if_pc
//   pred_target        predicted next PC for if_pc
//   upd_valid          EX holds a resolved conditional branch this cycle
//   upd_pc             PC of that branch
//   upd_taken          resolved direction
//   upd_target         resolved taken-target
//   upd_pred_taken     direction originally predicted for this branch
//   upd_pred_target    next PC originally predicted for this branch
//   flush              one-cycle pulse per mispredict
//   redirect_pc        correct next PC, valid while flush is high
//   br_count           resolved branches seen (saturating)
//   miss_count         mispredictions seen (saturating)
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic [1:0]       ctrTab    [ENTRIES];
  logic             validTab  [ENTRIES];
  logic [TAG_W-1:0] tagTab    [ENTRIES];
  logic [31:0]      targetTab [ENTRIES];

  logic [IDX_BITS-1:0] fetchIdx;
  logic [IDX_BITS-1:0] updIdx;
  logic [TAG_W-1:0]    fetchTag;
  logic [TAG_W-1:0]    updTag;
  logic                fetchHit;
  logic                updHit;
  logic                mis;

  assign fetchIdx = if_pc[IDX_BITS+1:2];
  assign fetchTag = if_pc[31:IDX_BITS+2];
  assign updIdx   = upd_pc[IDX_BITS+1:2];
  assign updTag   = upd_pc[31:IDX_BITS+2];

  // Lookup reads the flops directly, so a same-index update in this cycle
  // is only visible from the next cycle on.
  assign fetchHit    = validTab[fetchIdx] && (tagTab[fetchIdx] == fetchTag);
  assign pred_taken  = fetchHit && ctrTab[fetchIdx][1];
  assign pred_target = pred_taken ? targetTab[fetchIdx] : if_pc + 32'd4;

  assign updHit = validTab[updIdx] && (tagTab[updIdx] == updTag);

  // A taken branch is also wrong if it went somewhere other than predicted.
  assign mis = upd_valid &&
               ((upd_taken != upd_pred_taken) ||
                (upd_taken && (upd_target != upd_pred_target)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctrTab[i]    <= 2'b01;
        validTab[i]  <= 1'b0;
        tagTab[i]    <= '0;
        targetTab[i] <= '0;
      end
      flush       <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      miss_count  <= '0;
    end else begin
      flush <= mis;
      if (mis) begin
        redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      if (upd_valid) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (updHit) begin
          if (upd_taken) begin
            if (ctrTab[updIdx] != 2'b11) ctrTab[updIdx] <= ctrTab[updIdx] + 2'd1;
            targetTab[updIdx] <= upd_target;
          end else if (ctrTab[updIdx] != 2'b00) begin
            ctrTab[updIdx] <= ctrTab[updIdx] - 2'd1;
          end
        end else if (upd_taken) begin
          // Allocate weakly-taken, evicting whatever aliased to this index.
          validTab[updIdx]  <= 1'b1;
          tagTab[updIdx]    <= updTag;
          targetTab[updIdx] <= upd_target;
          ctrTab[updIdx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic             flush;
    logic [31:0]      redirect;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] miss;
  } regOut_t;

  logic              clk;
  logic              rst;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  miss_count;

  int checks = 0;
  int passes = 0;

  regOut_t sbQ[$];
  logic [CNT_W-1:0] expBr;
  logic [CNT_W-1:0] expMiss;
  logic [31:0]      expRedirect;

  branch_predictor #(.IDX_BITS(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic regOut_t actualRegs();
    return {flush, redirect_pc, br_count, miss_count};
  endfunction

  task automatic modelReset();
    expBr = '0;
    expMiss = '0;
    expRedirect = '0;
    sbQ.delete();
  endtask

  // Drives one resolved branch and pushes the registered outputs expected
  // after the next rising edge.
  task automatic applyUpdate(input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic pTaken,
                             input logic [31:0] pTarget);
    regOut_t e;
    logic m;
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = taken;
    upd_target = target;
    upd_pred_taken = pTaken;
    upd_pred_target = pTarget;
    m = (taken != pTaken) || (taken && (target != pTarget));
    if (expBr != CNT_MAX) expBr = expBr + 1'b1;
    if (m) begin
      if (expMiss != CNT_MAX) expMiss = expMiss + 1'b1;
      expRedirect = taken ? target : pc + 32'd4;
    end
    e.flush = m;
    e.redirect = expRedirect;
    e.br = expBr;
    e.miss = expMiss;
    sbQ.push_back(e);
  endtask

  task automatic clockStep();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic idleCycle();
    regOut_t e;
    upd_valid = 1'b0;
    e.flush = 1'b0;
    e.redirect = expRedirect;
    e.br = expBr;
    e.miss = expMiss;
    sbQ.push_back(e);
    clockStep();
  endtask

  task automatic test_reset();
    regOut_t e, a;
    rst = 1'b1;
    upd_valid = 1'b0;
    if_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    sbQ.push_back('0);
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL reset_regs: got %h expected %h", a, e); else passes++;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h44})
      $display("FAIL reset_pred: got %b/%h expected 0/00000044", pred_taken, pred_target);
    else passes++;
    if_pc = 32'hFFFF_FFFC;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0})
      $display("FAIL wrap_pred: got %b/%h expected 0/00000000", pred_taken, pred_target);
    else passes++;
  endtask

  task automatic test_allocate();
    regOut_t e, a;
    if_pc = 32'h40;
    applyUpdate(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL alloc_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100})
      $display("FAIL alloc_pred: got %b/%h expected 1/00000100", pred_taken, pred_target);
    else passes++;
    idleCycle();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL alloc_flush_drop: got %h expected %h", a, e); else passes++;
  endtask

  task automatic test_train_down();
    regOut_t e, a;
    if_pc = 32'h40;
    applyUpdate(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100})
      $display("FAIL collision_old_entry: got %b/%h expected 1/00000100", pred_taken, pred_target);
    else passes++;
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL nt1_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h44})
      $display("FAIL nt1_pred: got %b/%h expected 0/00000044", pred_taken, pred_target);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      applyUpdate(32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
      clockStep();
      e = sbQ.pop_front(); a = actualRegs(); checks++;
      if (a !== e) $display("FAIL nt_floor_regs[%0d]: got %h expected %h", k, a, e); else passes++;
    end
    // From 00 a single taken must only reach 01 (still not-taken).
    applyUpdate(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL floor_t1_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if (pred_taken !== 1'b0)
      $display("FAIL floor_sat_pred: got %b expected 0", pred_taken);
    else passes++;
    applyUpdate(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL floor_t2_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100})
      $display("FAIL floor_t2_pred: got %b/%h expected 1/00000100", pred_taken, pred_target);
    else passes++;
  endtask

  task automatic test_correct();
    regOut_t e, a;
    if_pc = 32'h40;
    for (int k = 0; k < 2; k++) begin
      applyUpdate(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      clockStep();
      e = sbQ.pop_front(); a = actualRegs(); checks++;
      if (a !== e) $display("FAIL correct_regs[%0d]: got %h expected %h", k, a, e); else passes++;
    end
    // Saturated at 11: one not-taken leaves it at 10, still predicting taken.
    applyUpdate(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL ceil_nt_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100})
      $display("FAIL ceil_sat_pred: got %b/%h expected 1/00000100", pred_taken, pred_target);
    else passes++;
    applyUpdate(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL target_miss_regs: got %h expected %h", a, e); else passes++;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h180})
      $display("FAIL target_retrain_pred: got %b/%h expected 1/00000180", pred_taken, pred_target);
    else passes++;
  endtask

  task automatic test_alias();
    regOut_t e, a;
    applyUpdate(32'h440, 1'b1, 32'h200, 1'b0, 32'h444);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL alias_regs: got %h expected %h", a, e); else passes++;
    if_pc = 32'h40;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h44})
      $display("FAIL alias_old_pred: got %b/%h expected 0/00000044", pred_taken, pred_target);
    else passes++;
    if_pc = 32'h440;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200})
      $display("FAIL alias_new_pred: got %b/%h expected 1/00000200", pred_taken, pred_target);
    else passes++;
    applyUpdate(32'h80, 1'b0, 32'h300, 1'b0, 32'h84);
    clockStep();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL miss_nt_regs: got %h expected %h", a, e); else passes++;
    if_pc = 32'h80;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h84})
      $display("FAIL miss_nt_noalloc: got %b/%h expected 0/00000084", pred_taken, pred_target);
    else passes++;
  endtask

  task automatic test_reset_priority();
    regOut_t e, a;
    rst = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h80;
    upd_taken = 1'b1;
    upd_target = 32'h300;
    upd_pred_taken = 1'b0;
    upd_pred_target = 32'h84;
    clockStep();
    rst = 1'b0;
    modelReset();
    sbQ.push_back('0);
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL rst_prio_regs: got %h expected %h", a, e); else passes++;
    if_pc = 32'h80;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h84})
      $display("FAIL rst_prio_noalloc: got %b/%h expected 0/00000084", pred_taken, pred_target);
    else passes++;
    if_pc = 32'h440;
    #1; checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h444})
      $display("FAIL rst_prio_cleared: got %b/%h expected 0/00000444", pred_taken, pred_target);
    else passes++;
  endtask

  task automatic test_back_to_back();
    regOut_t e, a;
    logic [31:0] pc;
    for (int i = 0; i < 70; i++) begin
      pc = 32'h1000 + 32'(i) * 32'd4;
      applyUpdate(pc, 1'b0, 32'h0, 1'b1, 32'h2000);
      clockStep();
      e = sbQ.pop_front(); a = actualRegs(); checks++;
      if (a !== e) $display("FAIL b2b_regs[%0d]: got %h expected %h", i, a, e); else passes++;
    end
    checks++;
    if ({br_count, miss_count} !== {CNT_MAX, CNT_MAX})
      $display("FAIL count_sat: got br=%0d miss=%0d expected %0d/%0d", br_count, miss_count, CNT_MAX, CNT_MAX);
    else passes++;
    idleCycle();
    e = sbQ.pop_front(); a = actualRegs(); checks++;
    if (a !== e) $display("FAIL final_idle: got %h expected %h", a, e); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    modelReset();
    test_reset();
    test_allocate();
    test_train_down();
    test_correct();
    test_alias();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
